// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded micro-op fields into 32-bit words,
// rejects out-of-range immediates and buffers legal words in a small FIFO.
module instr_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_kind,
    input  logic [$clog2(DATA_WIDTH)-1:0] rs1,
    input  logic [$clog2(DATA_WIDTH)-1:0] rs2,
    input  logic [$clog2(DATA_WIDTH)-1:0] rd,
    input  logic [DATA_WIDTH-1:0]         imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic                          err,
    output logic [7:0]                    err_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] KIND_LW   = 3'd0;
    localparam logic [2:0] KIND_SW   = 3'd1;
    localparam logic [2:0] KIND_ADDI = 3'd2;
    localparam logic [2:0] KIND_ADD  = 3'd3;
    localparam logic [2:0] KIND_SUB  = 3'd4;
    localparam logic [2:0] KIND_LUI  = 3'd5;
    localparam logic [2:0] KIND_BEQ  = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ZERO = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;
    logic [7:0]       err_count_reg, err_count_next;

    logic [DATA_WIDTH-1:0] encoded_word;
    logic                  enc_legal;
    logic                  imm12_ok;
    logic                  imm13_ok;
    logic                  lui_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Sign-extension checks: the bits above the field must all copy its sign bit.
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign lui_ok   = ~(|imm[11:0]);

    always_comb begin
        encoded_word = '0;
        enc_legal    = 1'b0;
        case (in_kind)
            KIND_LW: begin
                encoded_word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
                enc_legal    = imm12_ok;
            end
            KIND_SW: begin
                encoded_word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
                enc_legal    = imm12_ok;
            end
            KIND_ADDI: begin
                encoded_word = {imm[11:0], rs1, F3_ZERO, rd, OP_IMM};
                enc_legal    = imm12_ok;
            end
            KIND_ADD: begin
                encoded_word = {F7_ADD, rs2, rs1, F3_ZERO, rd, OP_REG};
                enc_legal    = 1'b1;
            end
            KIND_SUB: begin
                encoded_word = {F7_SUB, rs2, rs1, F3_ZERO, rd, OP_REG};
                enc_legal    = 1'b1;
            end
            KIND_LUI: begin
                encoded_word = {imm[31:12], rd, OP_LUI};
                enc_legal    = lui_ok;
            end
            KIND_BEQ: begin
                encoded_word = {imm[12], imm[10:5], rs2, rs1, F3_ZERO,
                                imm[4:1], imm[11], OP_BRANCH};
                enc_legal    = imm13_ok;
            end
            default: begin
                encoded_word = '0;
                enc_legal    = 1'b0;
            end
        endcase
    end

    // in_ready depends only on registered count, so out_ready never reaches it.
    assign in_ready  = (count_reg < DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign out_instr = mem[rd_ptr_reg];
    assign err       = err_reg;
    assign err_count = err_count_reg;

    assign accept = in_valid & in_ready;
    assign push   = accept & enc_legal;
    assign pop    = out_valid & out_ready;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        err_next       = 1'b0;
        err_count_next = err_count_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (accept && !enc_legal) begin
            err_next = 1'b1;
            if (err_count_reg != 8'hFF) begin
                err_count_next = err_count_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_reg] <= encoded_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder: the driver queues expected words,
// a negedge monitor tracks FIFO occupancy and error counts and compares outputs.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = 3'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    int m_cnt = 0;
    bit m_err = 1'b0;
    int m_errcnt = 0;
    bit model_on = 1'b0;
    int rdy_mode = 1;

    instr_encoder #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: RISC-V rules expressed as integer ranges and shifted fields.
    function automatic bit model_legal(input logic [2:0] k, input logic [31:0] im);
        int s;
        s = int'(im);
        case (k)
            3'd0, 3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3, 3'd4:       return 1'b1;
            3'd5:             return (im % 4096) == 0;
            3'd6:             return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] k, input logic [4:0] a,
                                               input logic [4:0] b, input logic [4:0] d,
                                               input logic [31:0] im);
        int unsigned u, ua, ub, ud;
        u = im; ua = a; ub = b; ud = d;
        case (k)
            3'd0: return ((u % 4096) << 20) | (ua << 15) | (2 << 12) | (ud << 7) | 32'h03;
            3'd1: return (((u / 32) % 128) << 25) | (ub << 20) | (ua << 15) | (2 << 12)
                         | ((u % 32) << 7) | 32'h23;
            3'd2: return ((u % 4096) << 20) | (ua << 15) | (ud << 7) | 32'h13;
            3'd3: return (ub << 20) | (ua << 15) | (ud << 7) | 32'h33;
            3'd4: return (32'd32 << 25) | (ub << 20) | (ua << 15) | (ud << 7) | 32'h33;
            3'd5: return (u - (u % 4096)) | (ud << 7) | 32'h37;
            3'd6: return (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (ub << 20)
                         | (ua << 15) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7)
                         | 32'h63;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance it by what the next edge will do.
    always @(negedge clk) begin : monitor
        bit acc, lg, pp;
        if (model_on) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_cnt < DEPTH});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_cnt != 0});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("err_count", {24'd0, err_count}, m_errcnt);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_instr got=%h expected=<none queued> t=%0t", out_instr, $time);
                end else begin
                    chk("out_instr", out_instr, exp_q[0]);
                end
            end
        end
        if (!rst_n) begin
            m_cnt = 0;
            m_err = 1'b0;
            m_errcnt = 0;
            exp_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            acc = in_valid && (m_cnt < DEPTH);
            lg  = model_legal(in_kind, imm);
            pp  = (m_cnt != 0) && out_ready;
            if (pp && exp_q.size() != 0) void'(exp_q.pop_front());
            m_err = acc && !lg;
            if (acc && !lg && m_errcnt < 255) m_errcnt++;
            m_cnt = m_cnt + ((acc && lg) ? 1 : 0) - (pp ? 1 : 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [31:0] im,
                        input bit use_gold, input logic [31:0] gold);
        int n;
        n = 0;
        if (use_gold) exp_q.push_back(gold);
        else if (model_legal(k, im)) exp_q.push_back(model_word(k, a, b, d, im));
        in_valid = 1'b1;
        in_kind = k; rs1 = a; rs2 = b; rd = d; imm = im;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 64);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=in_ready_low expected=accept within 64 cycles t=%0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d queued expected=0 t=%0t", exp_q.size(), $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edge_imm [10];
        logic [2:0]  k;
        logic [31:0] im;

        edge_imm = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094,
                     32'd4095, -32'sd4096, -32'sd4098, 32'd0, 32'd1};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single LW after reset.
        rdy_mode = 0;
        send(3'd0, 5'd21, 5'd0, 5'd21, 32'd0, 1'b1, 32'h000AAA83);
        wait_drain();

        // Back-to-back directed words.
        send(3'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h002081B3);
        send(3'd2, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
        send(3'd5, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, 32'h123452B7);
        send(3'd6, 5'd1, 5'd2, 5'd0, 32'd8, 1'b1, 32'h00208463);
        wait_drain();

        // Fill past capacity while stalled, then release.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(3'd2, 5'(i), 5'd0, 5'(i + 1), 32'(i * 3 - 5), 1'b0, 32'd0);
            end
            begin
                repeat (12) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Four illegal micro-ops, then a legal store.
        send(3'd2, 5'd1, 5'd0, 5'd1, 32'd2048, 1'b0, 32'd0);
        send(3'd5, 5'd0, 5'd0, 5'd2, 32'h00000001, 1'b0, 32'd0);
        send(3'd6, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0, 32'd0);
        send(3'd7, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("err_count_after_4", {24'd0, err_count}, 32'd4);
        chk("fifo_empty_after_illegal", {31'd0, out_valid}, 32'd0);
        send(3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE20AE23);
        wait_drain();

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++)
            send(3'd7, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("err_count_saturated", {24'd0, err_count}, 32'd255);

        // Reset with three words buffered.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            send(3'd3, 5'(i + 4), 5'(i + 9), 5'(i + 1), 32'd0, 1'b0, 32'd0);
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        rdy_mode = 0;
        send(3'd0, 5'd2, 5'd0, 5'd7, 32'd4, 1'b1, 32'h00412383);
        wait_drain();

        // Randomised traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            k = 3'($urandom_range(0, 7));
            case ($urandom % 4)
                0:       im = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       im = $urandom;
                2:       im = $urandom & 32'hFFFFF000;
                default: im = edge_imm[$urandom % 10];
            endcase
            send(k, 5'($urandom), 5'($urandom), 5'($urandom), im, 1'b0, 32'd0);
        end
        rdy_mode = 0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded micro-op fields (kind, rs1, rs2, rd, immediate) over a valid/ready handshake, range-checks the immediate, packs a 32-bit instruction word and buffers it in a small FIFO for a valid/ready consumer. It is the inverse of the core's `decoder`: it feeds the instruction memory loader and generates stimulus for the decoder and core benches. Any word it emits must decode back to the same fields.

## Interface
- `DATA_WIDTH`, 32: instruction width. Only 32 is supported.
- `FIFO_DEPTH`, 4: output buffer depth in words. Power of two, ≥2.
- `clk` input 1: single clock. Everything is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: micro-op present.
- `in_ready` output 1: encoder can accept a micro-op.
- `in_kind` input 3: 0=LW, 1=SW, 2=ADDI, 3=ADD, 4=SUB, 5=LUI, 6=BEQ, 7=reserved.
- `rs1`, `rs2`, `rd` input $clog2(DATA_WIDTH) each: register indices.
- `imm` input DATA_WIDTH: immediate, two's complement; byte offset for BEQ.
- `out_valid` output 1: FIFO head holds a word.
- `out_ready` input 1: consumer takes the head word.
- `out_instr` output DATA_WIDTH: FIFO head word. Value is only meaningful while `out_valid`=1.
- `err` output 1: one-cycle pulse; the previous accepted micro-op was rejected.
- `err_count` output 8: saturating count of rejected micro-ops.

## Operation
- Accept: `in_valid && in_ready`. Push: accept of a legal micro-op. Pop: `out_valid && out_ready`.
- Encodings (fields listed msb→lsb):
  - LW: imm[11:0] | rs1 | 010 | rd | 0000011.
  - SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - ADDI: imm[11:0] | rs1 | 000 | rd | 0010011.
  - ADD: 0000000 | rs2 | rs1 | 000 | rd | 0110011.
  - SUB: 0100000 | rs2 | rs1 | 000 | rd | 0110011.
  - LUI: imm[31:12] | rd | 0110111.
  - BEQ: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011.
- Unused register fields are ignored; they are never copied into the word.
- Legality rules. An accepted micro-op that breaks any rule is illegal:
  - LW, SW, ADDI: imm must be in −2048..2047. In other words, imm[31:11] is all zeros or all ones.
  - LUI: imm[11:0] must be 0.
  - BEQ: imm must be in −4096..4094 and imm[0] must be 0.
  - Kind 7 is always illegal.
- Illegal micro-op:
  - It is still accepted, i.e. the handshake completes.
  - Nothing is pushed to the FIFO.
  - `err`=1 in the next cycle.
  - `err_count` increments and saturates at 255.
- FIFO:
  - Circular buffer with read/write pointers and a count of 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - Strict in-order delivery.
- `in_ready` = (count < FIFO_DEPTH). It is registered-state only and has no combinational path from `out_ready`.
- `out_valid` = (count != 0). `out_instr` = mem[rd_ptr].

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - Pointers and count cleared, so `out_valid`=0 and `in_ready`=1.
  - `err`=0 and `err_count`=0.
  - FIFO contents are not cleared. `out_instr` is don't-care while `out_valid`=0.
  - Reset mid-stream discards all buffered words and any accept in that same cycle.
- Latency:
  - A word accepted at edge N is visible on `out_instr` with `out_valid`=1 after edge N when the FIFO was empty.
  - This is zero-bubble: throughput is one word per cycle.
- `err` rises after the edge that accepted the illegal op and falls one cycle later, unless another illegal op was accepted at that edge.
- Full FIFO: `in_ready`=0. A pop in that cycle frees a slot that is visible as `in_ready`=1 only in the next cycle.
- Simultaneous push and pop with 0 < count < FIFO_DEPTH: count is unchanged and both pointers advance.
- Empty FIFO: a pop is impossible because `out_valid`=0. A push and an `out_ready` in the same cycle yield only a push.
- Illegal accept with a simultaneous pop: count decrements by 1.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_instr` holds steady.

## Test plan
- Reset, then LW rs1=21 rd=21 imm=0 → next cycle `out_valid`=1, `out_instr`=32'h000AAA83; `err`=0.
- Back-to-back ADD x3,x1,x2; ADDI x1,x0,−1; LUI x5,imm=32'h12345000; BEQ x1,x2,+8 with `out_ready`=1 → words 32'h002081B3, 32'hFFF00093, 32'h123452B7, 32'h00208463 in order, one per cycle.
- `out_ready`=0, push 5 legal ops (FIFO_DEPTH=4) → `in_ready` drops after the 4th accept; the 5th is held. Raise `out_ready` → all 5 words emerge in order, pointers wrap, and `out_instr` is stable while stalled.
- ADDI imm=2048; LUI imm=32'h00000001; BEQ imm=3; kind=7 → four `err` pulses, `err_count`=4, FIFO stays empty; a following legal op still encodes correctly.
- Run 300 illegal ops → `err_count` saturates at 255.
- FIFO holding 3 words, assert `rst_n`=0 for one cycle → `out_valid`=0, `in_ready`=1, `err_count`=0; the next LW is the first word out.
